// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer: FSM states, R/W bit values, byte-op fields.
// Latency: n/a (types only).
// Backpressure: n/a.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SADR_W,
        ST_REG,
        ST_WDATA,
        ST_SADR_R,
        ST_RDATA,
        ST_RESP
    } seq_state_t;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef struct packed {
        logic [7:0] dat;
        logic       read;
        logic       first;
        logic       last;
    } byte_op_t;

    function automatic byte_op_t mk_op(logic [7:0] dat, logic read, logic first, logic last);
        byte_op_t op;
        op.dat   = dat;
        op.read  = read;
        op.first = first;
        op.last  = last;
        return op;
    endfunction

    function automatic logic is_byte_state(seq_state_t s);
        return (s == ST_SADR_W) || (s == ST_REG) || (s == ST_WDATA) ||
               (s == ST_SADR_R) || (s == ST_RDATA);
    endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin picker: combinational one-hot pick starting after the last winner.
// Latency: pick is same-cycle; winner latched on lock, pointer moves on adv.
// Backpressure: none; requesters hold req until serviced.
module i2c_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            lock,
    input  logic            adv,
    output logic [NREQ-1:0] pick
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        idx      = '0;
        found    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            win_idx <= '0;
        end else begin
            if (lock) win_idx <= pick_idx;
            if (adv)  ptr     <= IW'((int'(win_idx) + 1) % NREQ);
        end
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Arbitrates NREQ requesters and walks one register read/write through a byte-level I2C master.
// Latency: ARB -> first m_start 1 cycle; last m_done -> rsp_valid 1 cycle.
// Backpressure: one byte op outstanding; waits on m_done (`I2C_SEQ_TIMEOUT_EN adds a per-byte abort).
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [7*NREQ-1:0] req_sadr,
    input  logic [8*NREQ-1:0] req_reg,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              m_start,
    output logic [7:0]        m_byte,
    output logic              m_read,
    output logic              m_first,
    output logic              m_last,
    input  logic              m_done,
    input  logic              m_nack,
    input  logic [7:0]        m_rdata
);

    if (NREQ < 1 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("i2c_txn_sequencer: NREQ must be 1..8 and TIMEOUT_CYC >= 2");
    end

    seq_state_t      state, state_nxt;
    byte_op_t        op;
    logic            issued;
    logic            in_byte, byte_end, to_hit, to_fire;
    logic [NREQ-1:0] pick, gnt_q;
    logic            rw_q, sel_rw;
    logic [6:0]      sadr_q, sel_sadr;
    logic [7:0]      reg_q, sel_reg, wdata_q, sel_wdata, rdata_q;
    logic            err_q;

    i2c_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .lock (state == ST_ARB),
        .adv  (state == ST_RESP),
        .pick (pick)
    );

    always_comb begin
        sel_rw    = 1'b0;
        sel_sadr  = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                sel_rw    = req_rw[i];
                sel_sadr  = req_sadr[7*i +: 7];
                sel_reg   = req_reg[8*i +: 8];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // issued is low only on the entry cycle of a byte state, which is when m_start fires
    assign in_byte  = is_byte_state(state);
    assign byte_end = issued && m_done;
    assign to_fire  = to_hit && !m_done;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    // The m_start cycle counts as the first waiting cycle, so the abort lands TIMEOUT_CYC after it.
    always_ff @(posedge clk) begin
        if (rst)          to_cnt <= '0;
        else if (m_start) to_cnt <= TW'(1);
        else if (issued)  to_cnt <= to_cnt + TW'(1);
    end
    assign to_hit = issued && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        op        = '0;
        unique case (state)
            ST_IDLE:   if (|req) state_nxt = ST_ARB;
            ST_ARB:    state_nxt = (|pick) ? ST_SADR_W : ST_IDLE;
            ST_SADR_W: begin
                op = mk_op({sadr_q, WR}, 1'b0, 1'b1, 1'b0);
                if (byte_end) state_nxt = m_nack ? ST_RESP : ST_REG;
            end
            ST_REG: begin
                op = mk_op(reg_q, 1'b0, 1'b0, 1'b0);
                if (byte_end) state_nxt = m_nack ? ST_RESP : ((rw_q == RD) ? ST_SADR_R : ST_WDATA);
            end
            ST_WDATA: begin
                op = mk_op(wdata_q, 1'b0, 1'b0, 1'b1);
                if (byte_end) state_nxt = ST_RESP;
            end
            ST_SADR_R: begin
                op = mk_op({sadr_q, RD}, 1'b0, 1'b1, 1'b0);
                if (byte_end) state_nxt = m_nack ? ST_RESP : ST_RDATA;
            end
            ST_RDATA: begin
                op = mk_op(8'h00, 1'b1, 1'b0, 1'b1);
                if (byte_end) state_nxt = ST_RESP;
            end
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (to_fire) state_nxt = ST_RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            issued  <= 1'b0;
            gnt_q   <= '0;
            rw_q    <= 1'b0;
            sadr_q  <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            issued <= in_byte && (state_nxt == state);
            if (state == ST_ARB) begin
                gnt_q   <= pick;
                rw_q    <= sel_rw;
                sadr_q  <= sel_sadr;
                reg_q   <= sel_reg;
                wdata_q <= sel_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state_nxt == ST_IDLE) gnt_q <= '0;
            if ((byte_end && m_nack) || to_fire) err_q <= 1'b1;
            if (state == ST_RDATA && byte_end && !m_nack) rdata_q <= m_rdata;
        end
    end

    assign m_start   = in_byte && !issued;
    assign m_byte    = op.dat;
    assign m_read    = op.read;
    assign m_first   = op.first;
    assign m_last    = op.last;
    assign grant     = (state == ST_ARB) ? pick : gnt_q;
    assign rsp_valid = (state == ST_RESP) ? gnt_q : '0;
    assign rsp_err   = (state == ST_RESP) && err_q;
    assign rsp_rdata = (state == ST_RESP) ? rdata_q : 8'h00;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: byte-level master model plus a transaction-level reference.
// Drives and samples on the falling clock edge.
module tb_i2c_txn_sequencer;

    localparam int NREQ = 2;
    localparam int TOC  = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, req_rw;
    logic [7*NREQ-1:0] req_sadr;
    logic [8*NREQ-1:0] req_reg, req_wdata;
    logic [NREQ-1:0]   grant, rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              m_start, m_read, m_first, m_last;
    logic [7:0]        m_byte;
    logic              m_done, m_nack;
    logic [7:0]        m_rdata;

    always #5 clk = ~clk;

    i2c_txn_sequencer #(.NREQ(NREQ), .TIMEOUT_CYC(TOC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_sadr(req_sadr),
        .req_reg(req_reg), .req_wdata(req_wdata), .grant(grant), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .m_start(m_start), .m_byte(m_byte),
        .m_read(m_read), .m_first(m_first), .m_last(m_last), .m_done(m_done),
        .m_nack(m_nack), .m_rdata(m_rdata)
    );

    int checks = 0;
    int failures = 0;

    // what the master model saw during one transaction
    int              obs_n, obs_viol, obs_unstable, obs_rsp_lat, obs_start_cyc;
    logic [7:0]      obs_byte [0:7];
    logic            obs_read [0:7];
    logic            obs_first[0:7];
    logic            obs_last [0:7];
    logic [NREQ-1:0] obs_rsp_valid, obs_grant_start, obs_grant_rsp;
    logic            obs_err;
    logic [7:0]      obs_rdata;
    bit              obs_timeout;

    // reference: byte list of a full transaction, and round-robin start point
    int         exp_n;
    logic [7:0] exp_byte [0:3];
    logic       exp_read [0:3];
    logic       exp_first[0:3];
    logic       exp_last [0:3];
    int         rr_next;

    function automatic void model_txn(input logic rw, input logic [6:0] sadr,
                                      input logic [7:0] rg, input logic [7:0] wd);
        for (int k = 0; k < 4; k++) begin
            exp_byte[k] = 8'h00; exp_read[k] = 1'b0; exp_first[k] = 1'b0; exp_last[k] = 1'b0;
        end
        exp_byte[0] = {sadr, 1'b0}; exp_first[0] = 1'b1;
        exp_byte[1] = rg;
        if (rw) begin
            exp_byte[2] = {sadr, 1'b1}; exp_first[2] = 1'b1;
            exp_read[3] = 1'b1;         exp_last[3]  = 1'b1;
            exp_n = 4;
        end else begin
            exp_byte[2] = wd; exp_last[2] = 1'b1;
            exp_n = 3;
        end
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(rr_next + k) % NREQ]) return (rr_next + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic rw, input logic [6:0] sadr,
                           input logic [7:0] rg, input logic [7:0] wd);
        req_rw[i] = rw;
        req_sadr[7*i +: 7]  = sadr;
        req_reg[8*i +: 8]   = rg;
        req_wdata[8*i +: 8] = wd;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Byte-level master: answers every m_start after a random delay until rsp_valid.
    task automatic serve_txn(input int nack_at, input logic [7:0] rd, input int max_delay,
                             input bit scramble);
        int  cnt, last_done;
        bit  pending;
        cnt = 0; last_done = -100; pending = 0;
        obs_n = 0; obs_viol = 0; obs_unstable = 0; obs_rsp_lat = -1; obs_start_cyc = -1;
        obs_rsp_valid = '0; obs_grant_start = '0; obs_grant_rsp = '0;
        obs_err = 1'b0; obs_rdata = 8'h00; obs_timeout = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
            if (rsp_valid != '0) begin
                obs_rsp_valid = rsp_valid; obs_err = rsp_err; obs_rdata = rsp_rdata;
                obs_grant_rsp = grant; obs_rsp_lat = cyc - last_done; obs_timeout = 0;
                break;
            end
            if (m_start) begin
                if (pending) obs_viol++;
                if (obs_n == 0) begin
                    obs_start_cyc = cyc; obs_grant_start = grant;
                    if (scramble) rand_fields();
                end
                if (obs_n < 8) begin
                    obs_byte[obs_n] = m_byte; obs_read[obs_n] = m_read;
                    obs_first[obs_n] = m_first; obs_last[obs_n] = m_last;
                end
                obs_n++;
                pending = 1;
                cnt = $urandom_range(max_delay, 0);
            end else if (pending) begin
                if (obs_n <= 8 && {m_byte, m_read, m_first, m_last} !==
                    {obs_byte[obs_n-1], obs_read[obs_n-1], obs_first[obs_n-1], obs_last[obs_n-1]})
                    obs_unstable++;
                if (cnt == 0) begin
                    m_done = 1'b1; m_nack = (obs_n - 1 == nack_at); m_rdata = rd;
                    pending = 0; last_done = cyc;
                end else begin
                    cnt--;
                end
            end
        end
        m_done = 1'b0; m_nack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_rw = '0; req_sadr = '0; req_reg = '0; req_wdata = '0;
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rr_next = 0;
        @(negedge clk);
        checks++;
        if ({grant, rsp_valid, rsp_rdata, rsp_err, m_start, m_byte, m_read, m_first, m_last} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got grant=%b rsp_valid=%b m_start=%b m_byte=%h want all 0",
                     grant, rsp_valid, m_start, m_byte);
        end
        m_done = 1'b1; m_rdata = 8'hFF;
        @(negedge clk);
        m_done = 1'b0; m_rdata = 8'h00;
        @(negedge clk);
        checks++;
        if ({grant, rsp_valid, m_start} !== '0) begin
            failures++;
            $display("FAIL idle_m_done got grant=%b rsp_valid=%b m_start=%b want 0", grant, rsp_valid, m_start);
        end
    endtask

    task automatic test_write();
        repeat (2) @(negedge clk);
        set_req(0, 1'b0, 7'h10, 8'h2A, 8'hAC);
        req = 2'b01;
        model_txn(1'b0, 7'h10, 8'h2A, 8'hAC);
        serve_txn(-1, 8'h00, 3, 0);
        req = '0;
        rr_next = 1;
        checks++;
        if (obs_timeout || obs_n !== 3) begin
            failures++; $display("FAIL write_nbytes got %0d timeout=%0d want 3", obs_n, obs_timeout);
        end
        for (int b = 0; b < 3 && b < obs_n; b++) begin
            checks++;
            if ({obs_byte[b], obs_read[b], obs_first[b], obs_last[b]} !==
                {exp_byte[b], exp_read[b], exp_first[b], exp_last[b]}) begin
                failures++;
                $display("FAIL write_byte%0d got %h r%0d f%0d l%0d want %h r%0d f%0d l%0d", b,
                         obs_byte[b], obs_read[b], obs_first[b], obs_last[b],
                         exp_byte[b], exp_read[b], exp_first[b], exp_last[b]);
            end
        end
        checks++;
        if (obs_rsp_valid !== 2'b01 || obs_err !== 1'b0 || obs_grant_rsp !== 2'b01) begin
            failures++;
            $display("FAIL write_rsp got valid=%b err=%b grant=%b want 01 0 01", obs_rsp_valid, obs_err, obs_grant_rsp);
        end
        checks++;
        if (obs_start_cyc !== 1 || obs_rsp_lat !== 1 || obs_grant_start !== 2'b01) begin
            failures++;
            $display("FAIL write_latency got start=%0d rsp=%0d grant=%b want 1 1 01",
                     obs_start_cyc, obs_rsp_lat, obs_grant_start);
        end
        checks++;
        if (obs_viol !== 0 || obs_unstable !== 0) begin
            failures++; $display("FAIL write_handshake got restarts=%0d unstable=%0d want 0 0", obs_viol, obs_unstable);
        end
    endtask

    task automatic test_read();
        repeat (2) @(negedge clk);
        set_req(1, 1'b1, 7'h50, 8'h05, 8'h99);
        req = 2'b10;
        model_txn(1'b1, 7'h50, 8'h05, 8'h99);
        serve_txn(-1, 8'h3C, 3, 0);
        req = '0;
        rr_next = 0;
        checks++;
        if (obs_timeout || obs_n !== 4) begin
            failures++; $display("FAIL read_nbytes got %0d timeout=%0d want 4", obs_n, obs_timeout);
        end
        for (int b = 0; b < 4 && b < obs_n; b++) begin
            checks++;
            if ({obs_read[b], obs_first[b], obs_last[b]} !== {exp_read[b], exp_first[b], exp_last[b]} ||
                (!exp_read[b] && obs_byte[b] !== exp_byte[b])) begin
                failures++;
                $display("FAIL read_byte%0d got %h r%0d f%0d l%0d want %h r%0d f%0d l%0d", b,
                         obs_byte[b], obs_read[b], obs_first[b], obs_last[b],
                         exp_byte[b], exp_read[b], exp_first[b], exp_last[b]);
            end
        end
        checks++;
        if (obs_rsp_valid !== 2'b10 || obs_err !== 1'b0 || obs_rdata !== 8'h3C) begin
            failures++;
            $display("FAIL read_rsp got valid=%b err=%b rdata=%h want 10 0 3c", obs_rsp_valid, obs_err, obs_rdata);
        end
    endtask

    task automatic test_rr();
        int w;
        repeat (2) @(negedge clk);
        rand_fields();
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = rr_pick(req);
            model_txn(req_rw[w], req_sadr[7*w +: 7], req_reg[8*w +: 8], req_wdata[8*w +: 8]);
            serve_txn(-1, 8'($urandom), 4, 0);
            rr_next = (w + 1) % NREQ;
            checks++;
            if (obs_timeout || obs_rsp_valid !== NREQ'(1 << w) || obs_n !== exp_n || obs_byte[0] !== exp_byte[0]) begin
                failures++;
                $display("FAIL rr_txn%0d got valid=%b nbytes=%0d byte0=%h want valid=%b nbytes=%0d byte0=%h",
                         k, obs_rsp_valid, obs_n, obs_byte[0], NREQ'(1 << w), exp_n, exp_byte[0]);
            end
        end
        req = '0;
    endtask

    task automatic test_nack();
        repeat (2) @(negedge clk);
        set_req(0, 1'b0, 7'h33, 8'h44, 8'h55);
        req = 2'b01;
        serve_txn(1, 8'h77, 2, 0);
        req = '0;
        rr_next = 1;
        checks++;
        if (obs_timeout || obs_n !== 2) begin
            failures++; $display("FAIL nack_nbytes got %0d timeout=%0d want 2", obs_n, obs_timeout);
        end
        checks++;
        if (obs_rsp_valid !== 2'b01 || obs_err !== 1'b1 || obs_rdata !== 8'h00 || obs_rsp_lat !== 1) begin
            failures++;
            $display("FAIL nack_rsp got valid=%b err=%b rdata=%h lat=%0d want 01 1 00 1",
                     obs_rsp_valid, obs_err, obs_rdata, obs_rsp_lat);
        end
    endtask

    task automatic test_rst_mid();
        int  ns, since;
        bit  hit;
        logic [7:0] rd;
        ns = 0; since = 0; hit = 0;
        repeat (2) @(negedge clk);
        set_req(0, 1'b0, 7'h21, 8'h12, 8'hEE);
        req = 2'b01;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            m_done = 1'b0;
            if (m_start) begin
                ns++; since = 0;
                if (ns == 2) begin hit = 1; break; end
            end else begin
                since++;
                if (ns == 1 && since == 2) m_done = 1'b1;
            end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL rst_reach_reg got starts=%0d want 2", ns); end
        rst = 1'b1; req = '0; m_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, rsp_valid, rsp_rdata, rsp_err, m_start, m_byte, m_read, m_first, m_last} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got grant=%b rsp_valid=%b m_start=%b m_byte=%h want all 0",
                     grant, rsp_valid, m_start, m_byte);
        end
        rst = 1'b0;
        rr_next = 0;
        @(negedge clk);
        rd = 8'($urandom);
        set_req(1, 1'b1, 7'h2B, 8'hC4, 8'h00);
        req = 2'b10;
        serve_txn(-1, rd, 3, 0);
        req = '0;
        rr_next = 0;
        checks++;
        if (obs_timeout || obs_rsp_valid !== 2'b10 || obs_n !== 4 || obs_err !== 1'b0 || obs_rdata !== rd) begin
            failures++;
            $display("FAIL rst_after_txn got valid=%b nbytes=%0d err=%b rdata=%h want 10 4 0 %h",
                     obs_rsp_valid, obs_n, obs_err, obs_rdata, rd);
        end
    endtask

    task automatic test_timeout();
        int  c;
        int  events;
        bit  seen;
        seen = 0; events = 0;
        repeat (2) @(negedge clk);
        set_req(0, 1'b0, 7'h0F, 8'h01, 8'h02);
        req = 2'b01;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (m_start) seen = 1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL timeout_first_start got none want m_start"); end
`ifdef I2C_SEQ_TIMEOUT_EN
        for (c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) break;
        end
        checks++;
        if (c !== TOC || rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort got cycles=%0d valid=%b err=%b want %0d 01 1", c, rsp_valid, rsp_err, TOC);
        end
`else
        for (c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (rsp_valid != '0 || m_start) events++;
        end
        checks++;
        if (events !== 0 || m_byte !== 8'h1E || m_first !== 1'b1) begin
            failures++;
            $display("FAIL timeout_disabled_wait got events=%0d m_byte=%h first=%b want 0 1e 1",
                     events, m_byte, m_first);
        end
        m_done = 1'b1; m_nack = 1'b1;
        @(negedge clk);
        m_done = 1'b0; m_nack = 1'b0;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin
            failures++; $display("FAIL timeout_disabled_nack got valid=%b err=%b want 01 1", rsp_valid, rsp_err);
        end
`endif
        req = '0;
        rr_next = 1;
    endtask

    task automatic test_random();
        int w, nack_at, exp_cnt;
        logic rw;
        logic [7:0] rd, want_rd;
        for (int round = 0; round < 30; round++) begin
            repeat (2) @(negedge clk);
            rand_fields();
            req = NREQ'($urandom_range((1 << NREQ) - 1, 1));
            while (req != '0) begin
                w = rr_pick(req);
                rw = req_rw[w];
                model_txn(rw, req_sadr[7*w +: 7], req_reg[8*w +: 8], req_wdata[8*w +: 8]);
                nack_at = ($urandom_range(3, 0) == 0) ? $urandom_range(exp_n - 1, 0) : -1;
                exp_cnt = (nack_at >= 0) ? nack_at + 1 : exp_n;
                rd = 8'($urandom);
                want_rd = (nack_at < 0 && rw) ? rd : 8'h00;
                serve_txn(nack_at, rd, 4, 1);
                req[w] = 1'b0;
                rr_next = (w + 1) % NREQ;
                checks++;
                if (obs_timeout || obs_rsp_valid !== NREQ'(1 << w) || obs_n !== exp_cnt) begin
                    failures++;
                    $display("FAIL rand%0d_txn got valid=%b nbytes=%0d want valid=%b nbytes=%0d",
                             round, obs_rsp_valid, obs_n, NREQ'(1 << w), exp_cnt);
                end
                for (int b = 0; b < exp_cnt && b < obs_n; b++) begin
                    checks++;
                    if ({obs_read[b], obs_first[b], obs_last[b]} !== {exp_read[b], exp_first[b], exp_last[b]} ||
                        (!exp_read[b] && obs_byte[b] !== exp_byte[b])) begin
                        failures++;
                        $display("FAIL rand%0d_byte%0d got %h r%0d f%0d l%0d want %h r%0d f%0d l%0d", round, b,
                                 obs_byte[b], obs_read[b], obs_first[b], obs_last[b],
                                 exp_byte[b], exp_read[b], exp_first[b], exp_last[b]);
                    end
                end
                checks++;
                if (obs_err !== (nack_at >= 0) || obs_rdata !== want_rd || obs_rsp_lat !== 1 ||
                    obs_viol !== 0 || obs_unstable !== 0) begin
                    failures++;
                    $display("FAIL rand%0d_rsp got err=%b rdata=%h lat=%0d restarts=%0d unstable=%0d want %0d %h 1 0 0",
                             round, obs_err, obs_rdata, obs_rsp_lat, obs_viol, obs_unstable,
                             (nack_at >= 0), want_rd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_rr();
        test_nack();
        test_rst_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
